// File: rtl/i3c_target_sdr_if.sv
// Bus pins and data-stream handshakes of the I3C SDR target.
// The slave modport is the target's view; master is the controller/system side.
`timescale 1ns/1ps
interface i3c_target_sdr_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic       sel_od_pp_o;
    logic       addr_override_i;
    logic [6:0] addr_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       busy_o;
    logic       parity_err_o;
    logic       rx_overflow_o;

    modport slave (
        input  scl_i, sda_i, addr_override_i, addr_i, rx_ready_i, tx_data_i, tx_valid_i,
        output sda_o, sel_od_pp_o, rx_data_o, rx_valid_o, tx_ready_o, busy_o,
        parity_err_o, rx_overflow_o
    );

    modport master (
        output scl_i, sda_i, addr_override_i, addr_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  sda_o, sel_od_pp_o, rx_data_o, rx_valid_o, tx_ready_o, busy_o,
        parity_err_o, rx_overflow_o
    );
endinterface

// File: rtl/i3c_target_sdr.sv
// I3C SDR target for private reads/writes: decodes START/Sr/STOP, matches a
// 7-bit address, collects write bytes into a show-ahead RX FIFO (T-bit parity
// checked) and serves read bytes from a valid/ready stream with T-bit
// end-of-data signalling.
`timescale 1ns/1ps
module i3c_target_sdr #(
    parameter int unsigned RxFifoDepth = 4,
    parameter logic [6:0]  StaticAddr  = 7'h5A
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    i3c_target_sdr_if.slave bus
);
    localparam int unsigned PtrW      = (RxFifoDepth > 1) ? $clog2(RxFifoDepth) : 1;
    localparam logic [6:0]  BcastAddr = 7'h7E;
    localparam logic [PtrW:0] FullCount = (PtrW+1)'(RxFifoDepth);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_T, RD_DATA, RD_T, IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisation: bit 0 = SCL, bit 1 = SDA. Reset to the idle
    // (high) bus level so leaving reset never looks like an edge.
    // ------------------------------------------------------------------
    logic [1:0] pin_s1_reg, pin_s2_reg, pin_d_reg;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pin_s1_reg <= 2'b11;
            pin_s2_reg <= 2'b11;
            pin_d_reg  <= 2'b11;
        end else begin
            pin_s1_reg <= {bus.sda_i, bus.scl_i};
            pin_s2_reg <= pin_s1_reg;
            pin_d_reg  <= pin_s2_reg;
        end
    end

    logic sda_s, scl_rise, scl_fall, start_det, stop_det, scl_high;
    assign sda_s     = pin_s2_reg[1];
    assign scl_high  = pin_s2_reg[0] & pin_d_reg[0];
    assign scl_rise  = pin_s2_reg[0] & ~pin_d_reg[0];
    assign scl_fall  = ~pin_s2_reg[0] & pin_d_reg[0];
    assign start_det = scl_high & pin_d_reg[1] & ~pin_s2_reg[1];
    assign stop_det  = scl_high & ~pin_d_reg[1] & pin_s2_reg[1];

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic       ack_reg, ack_next;
    logic       rd_reg, rd_next;
    logic       wr_own_reg, wr_own_next;
    logic       t_reg, t_next;
    logic       sda_reg, sda_next;
    logic       pp_reg, pp_next;
    logic       tx_ready_reg, tx_ready_next;
    logic       parity_err_reg, parity_err_next;
    logic       overflow_reg, overflow_next;
    logic       push_req, load_tx;

    logic [6:0] my_addr;
    logic       own_match, bcast_w, rw_bit;
    assign my_addr   = bus.addr_override_i ? bus.addr_i : StaticAddr;
    assign rw_bit    = shift_reg[0];
    assign own_match = (shift_reg[7:1] == my_addr);
    assign bcast_w   = (shift_reg[7:1] == BcastAddr) && !rw_bit;

    // ------------------------------------------------------------------
    // RX FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [7:0]      rx_mem [RxFifoDepth];
    logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PtrW:0]   count_reg;
    logic            fifo_full, fifo_pop, fifo_push;

    assign fifo_full     = (count_reg == FullCount);
    assign fifo_pop      = bus.rx_ready_i && (count_reg != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign fifo_push     = push_req && (!fifo_full || fifo_pop);
    assign overflow_next = push_req && fifo_full && !fifo_pop;

    // FIFO storage write; contents need no reset, pointers define validity
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            rx_mem[wr_ptr_reg] <= shift_reg;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            if (fifo_push && !fifo_pop)      count_reg <= count_reg + (PtrW+1)'(1);
            else if (!fifo_push && fifo_pop) count_reg <= count_reg - (PtrW+1)'(1);
        end
    end

    // Protocol register bank
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            tx_shift_reg   <= '0;
            ack_reg        <= 1'b0;
            rd_reg         <= 1'b0;
            wr_own_reg     <= 1'b0;
            t_reg          <= 1'b0;
            sda_reg        <= 1'b1;
            pp_reg         <= 1'b0;
            tx_ready_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            tx_shift_reg   <= tx_shift_next;
            ack_reg        <= ack_next;
            rd_reg         <= rd_next;
            wr_own_reg     <= wr_own_next;
            t_reg          <= t_next;
            sda_reg        <= sda_next;
            pp_reg         <= pp_next;
            tx_ready_reg   <= tx_ready_next;
            parity_err_reg <= parity_err_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Next-state and bus-drive decisions; bus conditions override bit handling
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shift_next      = shift_reg;
        tx_shift_next   = tx_shift_reg;
        ack_next        = ack_reg;
        rd_next         = rd_reg;
        wr_own_next     = wr_own_reg;
        t_next          = t_reg;
        sda_next        = sda_reg;
        pp_next         = pp_reg;
        tx_ready_next   = 1'b0;
        parity_err_next = 1'b0;
        push_req        = 1'b0;
        load_tx         = 1'b0;

        if (start_det) begin
            state_next = ADDR;
            cnt_next   = '0;
            sda_next   = 1'b1;
            pp_next    = 1'b0;
        end else if (stop_det) begin
            state_next = IDLE;
            sda_next   = 1'b1;
            pp_next    = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: ;
                ADDR: begin
                    if (scl_rise && cnt_reg < 4'd8) begin
                        shift_next = {shift_reg[6:0], sda_s};
                        cnt_next   = cnt_reg + 4'd1;
                    end else if (scl_fall && cnt_reg == 4'd8) begin
                        if ((own_match && !rw_bit) || bcast_w || (own_match && rw_bit)) begin
                            state_next  = ADDR_ACK;
                            // A read with nothing to send is refused up front
                            ack_next    = !(rw_bit && !bus.tx_valid_i);
                            sda_next    = rw_bit && !bus.tx_valid_i;
                            pp_next     = 1'b0;
                            rd_next     = rw_bit;
                            wr_own_next = own_match && !rw_bit;
                        end else begin
                            state_next = IGNORE;
                            sda_next   = 1'b1;
                            pp_next    = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (ack_reg && rd_reg) begin
                            load_tx = 1'b1;
                        end else if (ack_reg && wr_own_reg) begin
                            state_next = WR_DATA;
                            cnt_next   = '0;
                            sda_next   = 1'b1;
                            pp_next    = 1'b0;
                        end else begin
                            // NACK, or broadcast CCC which is not handled here
                            state_next = IGNORE;
                            sda_next   = 1'b1;
                            pp_next    = 1'b0;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && cnt_reg < 4'd8) begin
                        shift_next = {shift_reg[6:0], sda_s};
                        cnt_next   = cnt_reg + 4'd1;
                    end else if (scl_fall && cnt_reg == 4'd8) begin
                        state_next = WR_T;
                        cnt_next   = '0;
                    end
                end
                WR_T: begin
                    if (scl_rise) begin
                        if (sda_s != ~^shift_reg) parity_err_next = 1'b1;
                        else                      push_req        = 1'b1;
                        state_next = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_reg < 4'd8) begin
                            sda_next      = tx_shift_reg[7];
                            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                            cnt_next      = cnt_reg + 4'd1;
                        end else begin
                            state_next = RD_T;
                            t_next     = bus.tx_valid_i;
                            sda_next   = bus.tx_valid_i;
                            pp_next    = 1'b1;
                        end
                    end
                end
                RD_T: begin
                    if (scl_fall) begin
                        if (t_reg) begin
                            load_tx = 1'b1;
                        end else begin
                            state_next = IGNORE;
                            sda_next   = 1'b1;
                            pp_next    = 1'b0;
                        end
                    end else if (scl_rise && t_reg) begin
                        // Hand the line back so the controller can force Sr/P
                        pp_next = 1'b0;
                    end
                end
                IGNORE: begin
                    sda_next = 1'b1;
                    pp_next  = 1'b0;
                end
                default: state_next = IDLE;
            endcase

            if (load_tx) begin
                state_next    = RD_DATA;
                sda_next      = bus.tx_data_i[7];
                pp_next       = 1'b1;
                tx_shift_next = {bus.tx_data_i[6:0], 1'b0};
                cnt_next      = 4'd1;
                tx_ready_next = 1'b1;
            end
        end
    end

    assign bus.sda_o         = sda_reg;
    assign bus.sel_od_pp_o   = pp_reg;
    assign bus.tx_ready_o    = tx_ready_reg;
    assign bus.parity_err_o  = parity_err_reg;
    assign bus.rx_overflow_o = overflow_reg;
    assign bus.rx_valid_o    = (count_reg != '0);
    assign bus.rx_data_o     = rx_mem[rd_ptr_reg];
    assign bus.busy_o        = ((state_reg == ADDR_ACK) && ack_reg) ||
                               (state_reg == WR_DATA) || (state_reg == WR_T) ||
                               (state_reg == RD_DATA) || (state_reg == RD_T);
endmodule

// File: tb/tb_i3c_target_sdr.sv
// Directed-plus-random bench: a bit-level I3C controller model drives the
// bus, a queue-based model predicts FIFO contents and pulse counts.
`timescale 1ns/1ps
module tb_i3c_target_sdr;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i3c_target_sdr_if bus ();

    i3c_target_sdr #(.RxFifoDepth(4), .StaticAddr(7'h5A)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    // Controller-side drive; SDA is a wired-AND of controller and target
    logic       scl, ctrl_sda, addr_ovr, rx_ready;
    logic [6:0] addr_rt;
    logic [7:0] tx_mem [8];
    int         tx_len = 0, tx_base = 0, tx_idx;
    int         par_cnt = 0, ovf_cnt = 0, txr_cnt = 0;
    int         total_cnt = 0, pass_cnt = 0, fail_cnt = 0;

    assign bus.scl_i           = scl;
    assign bus.sda_i           = ctrl_sda & bus.sda_o;
    assign bus.addr_override_i = addr_ovr;
    assign bus.addr_i          = addr_rt;
    assign bus.rx_ready_i      = rx_ready;
    assign tx_idx              = txr_cnt - tx_base;
    assign bus.tx_valid_i      = (tx_idx < tx_len);
    assign bus.tx_data_i       = tx_mem[tx_idx[2:0]];

    // Pulse monitors; tx_ready advances the TX stream
    always @(negedge clk) begin
        if (bus.parity_err_o)  par_cnt++;
        if (bus.rx_overflow_o) ovf_cnt++;
        if (bus.tx_ready_o)    txr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model of the write path
    logic [7:0] exp_q[$];
    int exp_par = 0, exp_ovf = 0;

    function automatic void model_write(input logic [7:0] d, input logic t);
        if ((($countones(d) + int'(t)) % 2) == 0) exp_par++;
        else if (exp_q.size() >= 4)                exp_ovf++;
        else                                       exp_q.push_back(d);
    endfunction

    function automatic logic good_t(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_clk(4); ctrl_sda = 1'b1;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); ctrl_sda = 1'b0;
        wait_clk(4); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4); ctrl_sda = 1'b0;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); ctrl_sda = 1'b1;
        wait_clk(8);
    endtask

    task automatic bit_xfer(input logic b, output logic r, output logic pp, output logic bz);
        wait_clk(4); ctrl_sda = b;
        wait_clk(4); scl = 1'b1;
        wait_clk(4);
        r  = bus.sda_i;
        pp = bus.sel_od_pp_o;
        bz = bus.busy_o;
        wait_clk(4); scl = 1'b0;
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack, output logic bz);
        logic [7:0] v;
        logic r, pp, b;
        v = {a, rw};
        for (int i = 7; i >= 0; i--) bit_xfer(v[i], r, pp, b);
        bit_xfer(1'b1, ack, pp, bz);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic t);
        logic r, pp, b;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r, pp, b);
        bit_xfer(t, r, pp, b);
    endtask

    task automatic read_byte(output logic [7:0] d, output logic t, output logic pp_all);
        logic r, pp, b;
        pp_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r, pp, b);
            d[i] = r;
            pp_all &= pp;
        end
        bit_xfer(1'b1, t, pp, b);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) begin
            chk({tag, "_valid"}, 32'(bus.rx_valid_o), 32'd1);
            chk({tag, "_data"}, 32'(bus.rx_data_o), 32'(exp_q[0]));
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        chk({tag, "_empty"}, 32'(bus.rx_valid_o), 32'd0);
    endtask

    task automatic write_txn(input logic [7:0] d, input logic t);
        logic ack, bz;
        bus_start();
        send_addr(7'h5A, 1'b0, ack, bz);
        chk("wtxn_ack", 32'(ack), 32'd0);
        write_byte(d, t);
        model_write(d, t);
        bus_stop();
    endtask

    initial begin
        logic ack, bz, t, ppa;
        logic [7:0] d, rb;
        int t0;

        rst_n = 1'b0; scl = 1'b1; ctrl_sda = 1'b1;
        addr_ovr = 1'b0; addr_rt = 7'h00; rx_ready = 1'b0;
        for (int i = 0; i < 8; i++) tx_mem[i] = 8'h00;
        wait_clk(5);
        chk("rst_sda", 32'(bus.sda_o), 32'd1);
        chk("rst_pp", 32'(bus.sel_od_pp_o), 32'd0);
        chk("rst_rxv", 32'(bus.rx_valid_o), 32'd0);
        chk("rst_txr", 32'(bus.tx_ready_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_perr", 32'(bus.parity_err_o), 32'd0);
        chk("rst_ovf", 32'(bus.rx_overflow_o), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        // Basic write of two good-parity bytes
        bus_start();
        send_addr(7'h5A, 1'b0, ack, bz);
        chk("wr_ack", 32'(ack), 32'd0);
        chk("wr_ack_busy", 32'(bz), 32'd1);
        write_byte(8'h11, 1'b1); model_write(8'h11, 1'b1);
        write_byte(8'hA5, 1'b1); model_write(8'hA5, 1'b1);
        bus_stop();
        chk("wr_perr", par_cnt, exp_par);
        chk("wr_busy_after", 32'(bus.busy_o), 32'd0);
        drain("wr");

        // Bad parity then a good byte
        bus_start();
        send_addr(7'h5A, 1'b0, ack, bz);
        write_byte(8'h03, 1'b0); model_write(8'h03, 1'b0);
        chk("bp_perr1", par_cnt, exp_par);
        chk("bp_fifo_unch", 32'(bus.rx_valid_o), 32'd0);
        write_byte(8'h01, 1'b0); model_write(8'h01, 1'b0);
        bus_stop();
        chk("bp_perr2", par_cnt, exp_par);
        drain("bp");

        // Overflow with depth 4
        bus_start();
        send_addr(7'h5A, 1'b0, ack, bz);
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h20 + i);
            write_byte(d, good_t(d)); model_write(d, good_t(d));
            if (i == 3) chk("ovf_before5", ovf_cnt, exp_ovf);
        end
        bus_stop();
        chk("ovf_after5", ovf_cnt, exp_ovf);
        drain("ovf");

        // Randomised writes, roughly a quarter with corrupted T bits
        bus_start();
        send_addr(7'h5A, 1'b0, ack, bz);
        for (int i = 0; i < 7; i++) begin
            d = 8'($urandom_range(0, 255));
            t = good_t(d) ^ ($urandom_range(0, 3) == 0);
            write_byte(d, t); model_write(d, t);
        end
        bus_stop();
        chk("rnd_perr", par_cnt, exp_par);
        chk("rnd_ovf", ovf_cnt, exp_ovf);
        drain("rnd");

        // Read: two bytes then end of data
        tx_mem[0] = 8'hC3; tx_mem[1] = 8'h3C; tx_base = txr_cnt; tx_len = 2;
        t0 = txr_cnt;
        bus_start();
        send_addr(7'h5A, 1'b1, ack, bz);
        chk("rd_ack", 32'(ack), 32'd0);
        read_byte(rb, t, ppa);
        chk("rd_b0", 32'(rb), 32'hC3);
        chk("rd_t0", 32'(t), 32'd1);
        chk("rd_pp0", 32'(ppa), 32'd1);
        read_byte(rb, t, ppa);
        chk("rd_b1", 32'(rb), 32'h3C);
        chk("rd_t1", 32'(t), 32'd0);
        chk("rd_pp1", 32'(ppa), 32'd1);
        bus_stop();
        chk("rd_txready", txr_cnt - t0, 2);

        // Read with nothing to send is NACKed
        tx_base = txr_cnt; tx_len = 0;
        bus_start();
        send_addr(7'h5A, 1'b1, ack, bz);
        chk("rd_empty_nack", 32'(ack), 32'd1);
        bus_stop();

        // Address matching
        bus_start();
        send_addr(7'h5B, 1'b0, ack, bz);
        chk("a5b_nack", 32'(ack), 32'd1);
        chk("a5b_busy", 32'(bz), 32'd0);
        bus_stop();
        addr_ovr = 1'b1; addr_rt = 7'h5B;
        bus_start();
        send_addr(7'h5B, 1'b0, ack, bz);
        chk("ovr_ack", 32'(ack), 32'd0);
        bus_stop();
        addr_ovr = 1'b0;
        bus_start();
        send_addr(7'h7E, 1'b0, ack, bz);
        chk("bc_ack", 32'(ack), 32'd0);
        write_byte(8'h11, 1'b1);
        bus_stop();
        chk("bc_ignored", 32'(bus.rx_valid_o), 32'd0);

        // Repeated START mid-write, then a read
        d = 8'($urandom_range(0, 255));
        tx_mem[0] = d; tx_base = txr_cnt; tx_len = 1;
        bus_start();
        send_addr(7'h5A, 1'b0, ack, bz);
        write_byte(8'h11, 1'b1); model_write(8'h11, 1'b1);
        bus_start();
        send_addr(7'h5A, 1'b1, ack, bz);
        chk("sr_ack", 32'(ack), 32'd0);
        read_byte(rb, t, ppa);
        chk("sr_data", 32'(rb), 32'(d));
        chk("sr_t", 32'(t), 32'd0);
        bus_stop();
        drain("sr");

        // Reset during a read while the target pulls SDA low
        write_txn(8'h11, 1'b1);
        tx_mem[0] = 8'h00; tx_base = txr_cnt; tx_len = 1;
        bus_start();
        send_addr(7'h5A, 1'b1, ack, bz);
        chk("rr_ack", 32'(ack), 32'd0);
        wait_clk(6);
        chk("rr_pre_sda", 32'(bus.sda_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_sda", 32'(bus.sda_o), 32'd1);
        chk("rr_pp", 32'(bus.sel_od_pp_o), 32'd0);
        chk("rr_rxv", 32'(bus.rx_valid_o), 32'd0);
        chk("rr_busy", 32'(bus.busy_o), 32'd0);
        exp_q.delete();
        wait_clk(3);
        rst_n = 1'b1;
        scl = 1'b1; ctrl_sda = 1'b1;
        wait_clk(8);

        // Normal operation after reset
        d = 8'($urandom_range(0, 255));
        write_txn(d, good_t(d));
        drain("post");
        chk("end_perr", par_cnt, exp_par);
        chk("end_ovf", ovf_cnt, exp_ovf);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
